mips: RTL and testbench
=======================

Name: mips

Overview:
- Single-cycle 32-bit MIPS processor core; executes one instruction per rising clock edge.
- Sits between a combinational instruction ROM (indexed by pc[7:2], 64 words) and a word-addressed data RAM (synchronous write, combinational read).
- Top-level harness pass criterion: the program stores value 7 to address 84.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded while reset is asserted.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- pc  output  32  current instruction address.
- instr  input  32  instruction at pc, combinational from instruction memory.
- memwrite  output  1  data-memory write enable for the current instruction.
- aluout  output  32  ALU result; used as the data-memory byte address.
- writedata  output  32  register rt contents; store data.
- readdata  input  32  data-memory read data, combinational on aluout.

Behaviour:
- Reset:
  - reset=0 forces pc=PC_RESET immediately, independent of clk.
  - memwrite follows instruction decode combinationally; it is 1 only if instr is sw.
  - Register file is not reset; $0 always reads 0 and writes to it are discarded.
- State: 32x32 register file (2 combinational read ports, 1 write port on rising clk) plus a 32-bit pc register. No other state.
- Instruction set:
  - R-type (op 000000): add, sub, and, or, slt; funct 100000, 100010, 100100, 100101, 101010. Writes rd.
  - lw (100011): rt <= readdata. Address = rs + signext(imm).
  - sw (101011): memwrite=1; writedata=rt; aluout = rs + signext(imm).
  - beq (000100): if rs==rt, pc <= pc+4 + (signext(imm)<<2); otherwise pc+4.
  - addi (001000): rt <= rs + signext(imm).
  - j (000010): pc <= {pc+4[31:28], addr26, 2'b00}.
- Arithmetic:
  - Two's-complement 32-bit wraparound.
  - No overflow traps.
  - slt is a signed compare producing 1 or 0.
- Unsupported opcode or funct: no register write, memwrite=0, pc <= pc+4.
- Timing:
  - Register write and pc update occur on the same rising edge.
  - A read of a register in the following cycle returns the new value.
  - A write to rs/rt in the same cycle as a read returns the old value (combinational read).
- Reset release: the first instruction executed is the one at PC_RESET; pc advances on the first rising edge with reset=1.
- Memories:
  - imem: 64x32 ROM, initialized from hex file memfile.dat.
  - dmem: 64x32 RAM; address bits [7:2] select the word; write on rising clk when memwrite=1; read is combinational.

Optional Feature:
- MIPS_BNE_EN:
  - Defined: opcode 000101 (bne) is decoded; branches when rs!=rt, using the same target computation as beq.
  - Undefined: opcode 000101 is treated as unsupported (pc+4, no side effects).

Test Plan:
- Reset: hold reset=0 across 3 edges, then release -> pc=0 throughout reset; pc=4 after the first edge following release.
- addi $2,$0,5; addi $3,$0,12; sub $4,$3,$2 -> $4=7. slt $5,$3,$2 -> $5=0. or $6,$2,$3 -> $6=13. and $7,$2,$3 -> $7=4.
- Standard test program (addi/add/or/and/slt/beq/lw/sw/j mix) -> only store writes 7 to aluout=84 (0x54); memwrite never asserted with an address other than 80 or 84.
- beq taken with imm=2 at pc=0x10 -> next pc=0x1C; not taken -> 0x14. j 0x11 -> pc=0x44.
- sw $2,80($0) with $2=7, then lw $9,80($0) -> memwrite=1, aluout=80 in the sw cycle; $9=7 afterwards.
- Async reset mid-program (reset low between edges) -> pc=0 before the next clk edge; stored dmem contents preserved.

Source files
------------

// File: rtl/mips_if.sv
// ---------------------------------------------------------------------------
// mips_if -- memory-side bus of the single-cycle MIPS core.
//
// Signals:
//   pc         core -> imem : current instruction address
//   instr      imem -> core : instruction at pc (combinational ROM read)
//   memwrite   core -> dmem : store enable for the current instruction
//   aluout     core -> dmem : ALU result, doubles as data byte address
//   writedata  core -> dmem : store data (register rt)
//   readdata   dmem -> core : load data (combinational read at aluout)
//
// Modports: master = processor core, slave = memory system.
// ---------------------------------------------------------------------------
interface mips_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output pc, memwrite, aluout, writedata,
    input  instr, readdata
  );

  modport slave (
    input  pc, memwrite, aluout, writedata,
    output instr, readdata
  );
endinterface

// File: rtl/mips.sv
// ---------------------------------------------------------------------------
// mips -- single-cycle 32-bit MIPS core (one instruction per rising clk).
//
// Supported: add, sub, and, or, slt, lw, sw, beq, addi, j.
// Anything else retires as a no-op (pc+4, no register write, no store).
//
// Ports:
//   clk    : system clock, all state updates on the rising edge
//   reset  : asynchronous, active-low; forces pc to PC_RESET immediately
//   bus    : mips_if.master -- pc/instr to imem, aluout/writedata/
//            memwrite/readdata to dmem
//
// Parameters:
//   PC_RESET : pc value held while reset is asserted
//
// Build option:
//   MIPS_BNE_EN : when defined, opcode 000101 (bne) is decoded and branches
//                 on rs != rt; otherwise it is treated as unsupported.
//
// State: 32x32 register file (not reset, $0 hardwired to zero) and pc.
// ---------------------------------------------------------------------------
module mips #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   reset,
  mips_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // -------------------------------------------------------------------------
  // Instruction fields
  // -------------------------------------------------------------------------
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic [31:0] imm_sext;

  assign opcode   = bus.instr[31:26];
  assign rs_addr  = bus.instr[25:21];
  assign rt_addr  = bus.instr[20:16];
  assign rd_addr  = bus.instr[15:11];
  assign funct    = bus.instr[5:0];
  assign imm_sext = {{16{bus.instr[15]}}, bus.instr[15:0]};

  // Shift amount is not used by any supported instruction.
  logic unused_shamt;
  assign unused_shamt = &{1'b0, bus.instr[10:6]};

  // -------------------------------------------------------------------------
  // Register file: combinational reads, write on rising edge.
  // A same-cycle write is not visible to the reads until the next cycle.
  // -------------------------------------------------------------------------
  logic [31:0] rf_q [32];
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  assign rs_val = (rs_addr == 5'd0) ? 32'h0 : rf_q[rs_addr];
  assign rt_val = (rt_addr == 5'd0) ? 32'h0 : rf_q[rt_addr];

  // -------------------------------------------------------------------------
  // Decode + ALU
  // -------------------------------------------------------------------------
  logic [31:0] alu_res;
  logic        reg_we;
  logic [4:0]  reg_dst;
  logic        wb_from_mem;
  logic        mem_we;
  logic        branch_taken;
  logic        jump;

  always_comb begin
    alu_res      = 32'h0;
    reg_we       = 1'b0;
    reg_dst      = rt_addr;
    wb_from_mem  = 1'b0;
    mem_we       = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        reg_dst = rd_addr;
        case (funct)
          FN_ADD: begin alu_res = rs_val + rt_val; reg_we = 1'b1; end
          FN_SUB: begin alu_res = rs_val - rt_val; reg_we = 1'b1; end
          FN_AND: begin alu_res = rs_val & rt_val; reg_we = 1'b1; end
          FN_OR:  begin alu_res = rs_val | rt_val; reg_we = 1'b1; end
          FN_SLT: begin
            alu_res = {31'h0, ($signed(rs_val) < $signed(rt_val))};
            reg_we  = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDI: begin
        alu_res = rs_val + imm_sext;
        reg_we  = 1'b1;
      end
      OP_LW: begin
        alu_res     = rs_val + imm_sext;
        reg_we      = 1'b1;
        wb_from_mem = 1'b1;
      end
      OP_SW: begin
        alu_res = rs_val + imm_sext;
        mem_we  = 1'b1;
      end
      OP_BEQ: begin
        alu_res      = rs_val - rt_val;
        branch_taken = (rs_val == rt_val);
      end
`ifdef MIPS_BNE_EN
      OP_BNE: begin
        alu_res      = rs_val - rt_val;
        branch_taken = (rs_val != rt_val);
      end
`endif
      OP_J: begin
        jump = 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Register write-back
  // -------------------------------------------------------------------------
  logic [31:0] wb_data;
  assign wb_data = wb_from_mem ? bus.readdata : alu_res;

  always_ff @(posedge clk) begin
    if (reg_we && (reg_dst != 5'd0)) begin
      rf_q[reg_dst] <= wb_data;
    end
  end

  // -------------------------------------------------------------------------
  // Program counter
  // -------------------------------------------------------------------------
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};

  always_comb begin
    pc_d = pc_plus4;
    if (jump) begin
      pc_d = {pc_plus4[31:28], bus.instr[25:0], 2'b00};
    end else if (branch_taken) begin
      pc_d = branch_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  // -------------------------------------------------------------------------
  // Bus outputs
  // -------------------------------------------------------------------------
  assign bus.pc        = pc_q;
  assign bus.memwrite  = mem_we;
  assign bus.aluout    = alu_res;
  assign bus.writedata = rt_val;

endmodule

// File: tb/tb_mips.sv
// ---------------------------------------------------------------------------
// tb_mips -- directed-vector bench for the single-cycle MIPS core.
// Provides a 64-word instruction ROM and 64-word data RAM around the core,
// runs a hand-assembled program and compares pc / aluout / memwrite /
// writedata against hand-computed values for every executed instruction.
// ---------------------------------------------------------------------------
module tb_mips;

  logic clk;
  logic reset;

  mips_if bus ();

  mips #(
    .PC_RESET(32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction ROM and data RAM models
  logic [31:0] imem [64];
  logic [31:0] dmem [64];

  assign bus.instr    = imem[bus.pc[7:2]];
  assign bus.readdata = dmem[bus.aluout[7:2]];

  always @(posedge clk) begin
    if (bus.memwrite) begin
      dmem[bus.aluout[7:2]] <= bus.writedata;
    end
  end

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic        mw;
    logic [31:0] wd;
    bit          chk_alu;
    bit          chk_wd;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [31:0] pc, input logic [31:0] alu, input logic mw,
                         input logic [31:0] wd, input bit chk_alu, input bit chk_wd);
    vec_t v;
    v.pc = pc; v.alu = alu; v.mw = mw; v.wd = wd;
    v.chk_alu = chk_alu; v.chk_wd = chk_wd;
    vecs.push_back(v);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    reset = 1'b0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;

    imem[0]  = 32'h2002_0005; // 00 addi $2,$0,5
    imem[1]  = 32'h2003_000C; // 04 addi $3,$0,12
    imem[2]  = 32'h0062_2022; // 08 sub  $4,$3,$2    -> 7
    imem[3]  = 32'h0062_282A; // 0C slt  $5,$3,$2    -> 0
    imem[4]  = 32'h0043_3025; // 10 or   $6,$2,$3    -> 13
    imem[5]  = 32'h0043_3824; // 14 and  $7,$2,$3    -> 4
    imem[6]  = 32'h0043_282A; // 18 slt  $5,$2,$3    -> 1
    imem[7]  = 32'hAC04_0050; // 1C sw   $4,80($0)
    imem[8]  = 32'h8C09_0050; // 20 lw   $9,80($0)
    imem[9]  = 32'hAC09_0054; // 24 sw   $9,84($0)   -> stores 7 at 84
    imem[10] = 32'h1043_0002; // 28 beq  $2,$3,+2    not taken
    imem[11] = 32'h1042_0002; // 2C beq  $2,$2,+2    taken -> 38
    imem[12] = 32'hAC03_0054; // 30 (skipped)
    imem[13] = 32'hAC03_0054; // 34 (skipped)
    imem[14] = 32'h0800_0011; // 38 j    0x11        -> 44
    imem[17] = 32'hFC00_0000; // 44 unsupported opcode
    imem[18] = 32'h0063_103F; // 48 unsupported funct, rd=$2
    imem[19] = 32'hAC02_0050; // 4C sw   $2,80($0)   -> $2 still 5
    imem[20] = 32'h1443_0001; // 50 bne  $2,$3,+1
    imem[21] = 32'h2000_0001; // 54 addi $0,$0,1     (discarded)
    imem[22] = 32'hAC00_0050; // 58 sw   $0,80($0)   -> stores 0
    imem[23] = 32'h200B_FFFF; // 5C addi $11,$0,-1
    imem[24] = 32'h0162_602A; // 60 slt  $12,$11,$2  -> 1 (signed)
    imem[25] = 32'h0162_6820; // 64 add  $13,$11,$2  -> 4 (wraps)
    imem[26] = 32'h0800_001A; // 68 j    0x1A        -> 68

    //        pc          aluout       mw    wd          alu? wd?
    add_vec(32'h00, 32'd5,         1'b0, 32'h0, 1, 0);
    add_vec(32'h04, 32'd12,        1'b0, 32'h0, 1, 0);
    add_vec(32'h08, 32'd7,         1'b0, 32'h0, 1, 0);
    add_vec(32'h0C, 32'd0,         1'b0, 32'h0, 1, 0);
    add_vec(32'h10, 32'd13,        1'b0, 32'h0, 1, 0);
    add_vec(32'h14, 32'd4,         1'b0, 32'h0, 1, 0);
    add_vec(32'h18, 32'd1,         1'b0, 32'h0, 1, 0);
    add_vec(32'h1C, 32'd80,        1'b1, 32'd7, 1, 1);
    add_vec(32'h20, 32'd80,        1'b0, 32'h0, 1, 0);
    add_vec(32'h24, 32'd84,        1'b1, 32'd7, 1, 1);
    add_vec(32'h28, 32'h0,         1'b0, 32'h0, 0, 0);
    add_vec(32'h2C, 32'h0,         1'b0, 32'h0, 0, 0);
    add_vec(32'h38, 32'h0,         1'b0, 32'h0, 0, 0);
    add_vec(32'h44, 32'h0,         1'b0, 32'h0, 0, 0);
    add_vec(32'h48, 32'h0,         1'b0, 32'h0, 0, 0);
    add_vec(32'h4C, 32'd80,        1'b1, 32'd5, 1, 1);
    add_vec(32'h50, 32'h0,         1'b0, 32'h0, 0, 0);
`ifndef MIPS_BNE_EN
    add_vec(32'h54, 32'd1,         1'b0, 32'h0, 1, 0);
`endif
    add_vec(32'h58, 32'd80,        1'b1, 32'h0, 1, 1);
    add_vec(32'h5C, 32'hFFFF_FFFF, 1'b0, 32'h0, 1, 0);
    add_vec(32'h60, 32'd1,         1'b0, 32'h0, 1, 0);
    add_vec(32'h64, 32'd4,         1'b0, 32'h0, 1, 0);
    add_vec(32'h68, 32'h0,         1'b0, 32'h0, 0, 0);
    add_vec(32'h68, 32'h0,         1'b0, 32'h0, 0, 0);

    // Reset held across three rising edges
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      $display("reset edge %0d pc=%h", i, bus.pc);
      check("reset_pc", bus.pc, 32'h0);
    end

    @(negedge clk);
    reset = 1'b1;
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      $display("vec %0d pc=%h instr=%h aluout=%h memwrite=%0d writedata=%h",
               i, bus.pc, bus.instr, bus.aluout, bus.memwrite, bus.writedata);
      check("pc", bus.pc, vecs[i].pc);
      check("memwrite", {31'h0, bus.memwrite}, {31'h0, vecs[i].mw});
      if (vecs[i].chk_alu) check("aluout", bus.aluout, vecs[i].alu);
      if (vecs[i].chk_wd)  check("writedata", bus.writedata, vecs[i].wd);
      @(negedge clk);
      #1;
    end

    // Asynchronous reset between edges: pc must clear before any clock edge
    #2;
    reset = 1'b0;
    #1;
    $display("async reset pc=%h", bus.pc);
    check("async_rst_pc", bus.pc, 32'h0);
    @(negedge clk);
    #1;
    check("async_rst_hold", bus.pc, 32'h0);
    reset = 1'b1;
    #1;
    $display("restart pc=%h aluout=%h", bus.pc, bus.aluout);
    check("restart_alu", bus.aluout, 32'd5);
    @(negedge clk);
    #1;
    $display("restart+1 pc=%h aluout=%h", bus.pc, bus.aluout);
    check("restart_pc", bus.pc, 32'h4);
    check("restart_alu2", bus.aluout, 32'd12);
    check("dmem84_kept", dmem[21], 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
